// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO behind a valid/ready handshake feeding a serialiser
// that emits start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_tx_valid,
  input  logic [7:0]                    i_tx_byte,
  output logic                          o_tx_ready,
  output logic                          o_tx_serial,
  output logic                          o_tx_active,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [15:0] BitEnd   = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO state
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q, ready_d;
  logic            push, pop;

  // Serialiser state
  state_e     state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic        frame_end;
  logic        par_bit;

  // Handshake uses the registered ready, so i_tx_valid never feeds back into o_tx_ready.
  assign push = i_tx_valid & ready_q;

  // FIFO pointer, occupancy and ready next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
    ready_d = (count_d != Full);
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) mem_q[wr_ptr_q] <= i_tx_byte;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign bit_end = (cnt_q == BitEnd);
  assign par_bit = (PARITY == 2) ? (^shift_q) : ~(^shift_q);

  // Serialiser next-state; outputs are derived from the current state and registered,
  // so the line lags the state register by one cycle uniformly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == StopLast) begin
            frame_end = 1'b1;
            bit_idx_d = '0;
            // Back-to-back frames: reload straight into START with no idle cycle.
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered line, activity and done outputs
  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_q[bit_idx_q];
      StParity: serial_d = par_bit;
      default:  serial_d = 1'b1;
    endcase
    active_d = (state_q != StIdle);
    done_d   = frame_end;
  end

  // Serialiser state machine and its output flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_tx_ready   = ready_q;
  assign o_tx_serial  = serial_q;
  assign o_tx_active  = active_q;
  assign o_tx_done    = done_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor
// decodes every frame cycle by cycle and compares against the queue head.
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [11:0] bits;  // bit 0 is the start bit, sent first
    int          nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic [2:0] vld = 3'b000;
  logic [2:0] rdy, ser, act, dn;
  logic [2:0] cnt0, cnt1, cnt2;

  int sel = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int frames_seen = 0;
  int gap_cnt = 0;
  bit mon_busy = 0;
  frame_t exp_q[$];
  int gap_q[$];

  logic mon_serial, mon_active, mon_done, mon_ready;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .i_tx_valid(vld[0]), .i_tx_byte(tx_byte),
    .o_tx_ready(rdy[0]), .o_tx_serial(ser[0]), .o_tx_active(act[0]),
    .o_tx_done(dn[0]), .o_fifo_count(cnt0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) dut_even (
    .clk(clk), .reset(reset), .i_tx_valid(vld[1]), .i_tx_byte(tx_byte),
    .o_tx_ready(rdy[1]), .o_tx_serial(ser[1]), .o_tx_active(act[1]),
    .o_tx_done(dn[1]), .o_fifo_count(cnt1)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut_odd (
    .clk(clk), .reset(reset), .i_tx_valid(vld[2]), .i_tx_byte(tx_byte),
    .o_tx_ready(rdy[2]), .o_tx_serial(ser[2]), .o_tx_active(act[2]),
    .o_tx_done(dn[2]), .o_fifo_count(cnt2)
  );

  always_comb begin
    mon_serial = ser[sel];
    mon_active = act[sel];
    mon_done   = dn[sel];
    mon_ready  = rdy[sel];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  function automatic logic [11:0] frame8n1(input logic [7:0] b);
    return {3'b001, b, 1'b0};
  endfunction

  // Offer a byte to the selected instance until accepted; valid stays high afterwards.
  task automatic send(input logic [7:0] b, input logic [11:0] bits, input int nb);
    bit ok = 0;
    frame_t f;
    @(negedge clk);
    tx_byte  = b;
    vld      = '0;
    vld[sel] = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (mon_ready) begin
        @(posedge clk);
        f.bits  = bits;
        f.nbits = nb;
        exp_q.push_back(f);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    vld = '0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !mon_busy) begin
        ok = 1;
        break;
      end
    end
    check("drain", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: checks every cycle of each frame against the queue head.
  initial begin : monitor
    frame_t e;
    bit just_ended = 0;
    bit aborted;
    int bad_bits, bad_act, bad_done, last;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        just_ended = 0;
      end else if (mon_serial === 1'b0) begin
        mon_busy = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(exp_q.size()), 32'd1);
          e.bits  = '1;
          e.nbits = (sel == 0) ? 10 : 12;
        end else begin
          e = exp_q.pop_front();
        end
        gap_q.push_back(gap_cnt);
        gap_cnt  = 0;
        bad_bits = 0;
        bad_act  = 0;
        bad_done = 0;
        aborted  = 0;
        last     = e.nbits * CPB - 1;
        for (int c = 0; c <= last; c++) begin
          if (c > 0) @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (mon_serial !== e.bits[c / CPB]) bad_bits++;
          if (mon_active !== 1'b1) bad_act++;
          if (mon_done !== (c == last)) bad_done++;
        end
        if (!aborted) begin
          check("frame_bit_errors", 32'(bad_bits), 32'd0);
          check("frame_active_errors", 32'(bad_act), 32'd0);
          check("frame_done_errors", 32'(bad_done), 32'd0);
          frames_seen++;
          just_ended = 1;
        end
        mon_busy = 0;
      end else begin
        if (just_ended) check("active_low_after_frame", 32'(mon_active), 32'd0);
        just_ended = 0;
        gap_cnt++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin : stim
    int prev;
    int seen0;
    bit ok;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial", 32'(ser[0]), 32'd1);
    check("rst_active", 32'(act[0]), 32'd0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_ready", 32'(rdy[0]), 32'd1);
    check("rst_count", 32'(cnt0), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: latency and frame shape
    send(8'hA5, 12'b00_1_10100101_0, 10);
    drop_valid();
    check("a5_count_after_push", 32'(cnt0), 32'd1);
    check("a5_line_idle_n1", 32'(ser[0]), 32'd1);
    @(negedge clk);
    check("a5_count_after_pop", 32'(cnt0), 32'd0);
    check("a5_line_idle_n2", 32'(ser[0]), 32'd1);
    @(negedge clk);
    check("a5_line_start", 32'(ser[0]), 32'd0);
    wait_idle();

    // Back-to-back frames
    gap_q.delete();
    send(8'h00, frame8n1(8'h00), 10);
    send(8'hFF, frame8n1(8'hFF), 10);
    send(8'h3C, frame8n1(8'h3C), 10);
    send(8'h81, frame8n1(8'h81), 10);
    drop_valid();
    check("b2b_count", 32'(cnt0), 32'd3);
    wait_idle();
    check("b2b_frames", 32'(gap_q.size()), 32'd4);
    for (int i = 1; i < 4 && i < gap_q.size(); i++) check("b2b_gap", 32'(gap_q[i]), 32'd0);

    // Hold valid with 6 bytes: fill, stall, reject on the pop edge, then accept
    seen0 = frames_seen;
    send(8'h11, frame8n1(8'h11), 10);
    send(8'h22, frame8n1(8'h22), 10);
    send(8'h33, frame8n1(8'h33), 10);
    send(8'h44, frame8n1(8'h44), 10);
    send(8'h55, frame8n1(8'h55), 10);
    @(negedge clk);
    tx_byte = 8'h66;
    check("full_count", 32'(cnt0), 32'd4);
    check("full_ready", 32'(rdy[0]), 32'd0);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      prev = int'(cnt0);
      if (rdy[0]) begin
        @(posedge clk);
        exp_q.push_back('{bits: frame8n1(8'h66), nbits: 10});
        ok = 1;
        break;
      end
      @(negedge clk);
      if (int'(cnt0) != prev) check("full_pop_rejects_push", 32'(cnt0), 32'(prev - 1));
    end
    check("stall_accept", 32'(ok), 32'd1);
    drop_valid();
    check("stall_count_after_accept", 32'(cnt0), 32'd4);
    wait_idle();
    check("six_frames", 32'(frames_seen - seen0), 32'd6);

    // Parity and two stop bits
    sel = 1;
    send(8'h07, 12'b11_1_00000111_0, 12);
    drop_valid();
    wait_idle();
    sel = 2;
    send(8'h07, 12'b11_0_00000111_0, 12);
    drop_valid();
    wait_idle();
    sel = 0;

    // Reset during data bit 3 with a second byte queued
    send(8'hC3, frame8n1(8'hC3), 10);
    send(8'h99, frame8n1(8'h99), 10);
    drop_valid();
    repeat (18) @(negedge clk);
    check("mid_bit3_line", 32'(ser[0]), 32'd0);
    check("mid_active", 32'(act[0]), 32'd1);
    #1 reset = 1'b0;
    #1;
    exp_q.delete();
    check("abort_serial", 32'(ser[0]), 32'd1);
    check("abort_active", 32'(act[0]), 32'd0);
    check("abort_count", 32'(cnt0), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    seen0 = frames_seen;
    send(8'h5A, frame8n1(8'h5A), 10);
    drop_valid();
    wait_idle();
    check("post_reset_frame", 32'(frames_seen - seen0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
